// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage types and constants used by the multiply/divide unit.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: sign-magnitude operands, 32-step shift-add or
// restoring divide, then a sign fix. Division corner cases bypass the iteration.
module muldiv_unit
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  muldiv_state_t     state, state_next;
  muldiv_op_t        op_in, op_q;
  logic              neg_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   quot_q;
  logic [XLEN:0]     rem_q;
  logic [4:0]        cnt_q;
  logic [XLEN-1:0]   result_next;

  // Operand decode for an incoming request
  logic            signed_a_c, signed_b_c, is_div_c;
  logic            a_neg_c, b_neg_c, neg_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;
  logic            div_zero_c, ovf_c;
  logic [XLEN-1:0] special_c;

  assign op_in      = muldiv_op_t'(op);
  assign is_div_c   = op[2];
  assign signed_a_c = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV)  || (op_in == OP_REM);
  assign signed_b_c = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign a_neg_c    = signed_a_c & src_a[XLEN-1];
  assign b_neg_c    = signed_b_c & src_b[XLEN-1];
  assign a_mag_c    = a_neg_c ? -src_a : src_a;
  assign b_mag_c    = b_neg_c ? -src_b : src_b;
  assign neg_c      = (op_in == OP_REM) ? a_neg_c : (a_neg_c ^ b_neg_c);
  assign div_zero_c = is_div_c && (src_b == '0);
  assign ovf_c      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (src_a == INT_MIN) && (src_b == '1);

  always_comb begin
    special_c = '0;
    if (div_zero_c)
      special_c = op[1] ? src_a : DIV_ZERO_Q;
    else if (ovf_c)
      special_c = op[1] ? '0 : INT_MIN;
  end

  // One iteration step of each datapath
  logic [XLEN:0]   mul_sum_c;
  logic [XLEN+1:0] div_shift_c, div_trial_c;

  assign mul_sum_c   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                       (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  assign div_shift_c = {rem_q, quot_q[XLEN-1]};
  assign div_trial_c = div_shift_c - {2'b00, mcand_q};

  // Sign-corrected magnitudes for FIX
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quo_c, rem_c;

  assign prod_c = neg_q ? -acc_q : acc_q;
  assign quo_c  = neg_q ? -quot_q : quot_q;
  assign rem_c  = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  // Next-state and result selection
  always_comb begin
    state_next  = state;
    result_next = result;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (div_zero_c || ovf_c) begin
            state_next  = S_DONE;
            result_next = special_c;
          end else begin
            state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (cnt_q == 5'd31)
          state_next = S_FIX;
      end
      S_FIX: begin
        state_next = S_DONE;
        case (op_q)
          OP_MUL:                       result_next = prod_c[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_next = prod_c[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              result_next = quo_c;
          default:                      result_next = rem_c;
        endcase
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != S_IDLE);
      done   <= (state_next == S_DONE);
      result <= result_next;
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_in;
            neg_q   <= neg_c;
            cnt_q   <= '0;
            mcand_q <= is_div_c ? b_mag_c : a_mag_c;
            acc_q   <= {{XLEN{1'b0}}, b_mag_c};
            quot_q  <= a_mag_c;
            rem_q   <= '0;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (op_q[2]) begin
            quot_q <= {quot_q[XLEN-2:0], ~div_trial_c[XLEN+1]};
            rem_q  <= div_trial_c[XLEN+1] ? div_shift_c[XLEN:0] : div_trial_c[XLEN:0];
          end else begin
            acc_q <= {mul_sum_c, acc_q[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
